pio_in_debounce_irq: RTL
========================

# pio_in_debounce_irq

Parametrised Avalon-MM switch/button PIO for the Nios system: synchronises a WIDTH-bit external input, debounces it, exposes the clean value, and captures edges into a sticky register. Masked edges drive an interrupt line to the processor. It also retains a WIDTH-bit output latch. It replaces the fixed 18-bit input-only PIO on the system interconnect.

## Interface
- WIDTH, 18: input/output port width, 1..32.
- DEBOUNCE_CYCLES, 50000: cycles the synchronised input must hold before acceptance, ≥1; counter width is clog2(DEBOUNCE_CYCLES)+1.
- EDGE_MODE, 2: which edges are captured. 0 = rising, 1 = falling, 2 = any.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [WIDTH-1:0] used
- in_port  in  WIDTH  raw external input, asynchronous to clk
- readdata  out  32  registered read data, zero-extended above WIDTH
- out_port  out  WIDTH  output latch
- irq  out  1  level interrupt: |(edgecapture & irqmask)

## Operation
- Register map:
  - Address 0, read: debounced value. Write: loads out_port.
  - Address 1: irqmask, R/W.
  - Address 2, read: edgecapture. Write: write-1-to-clear per bit.
  - Address 3, read: out_port readback. Writes are ignored.
- A write is a cycle with chipselect=1 and write_n=0. Writes to bits ≥WIDTH are ignored.
- Synchroniser: two flops, sync1 → sync2.
- Debounce, one shared counter cnt over the whole vector:
  - If sync2 ≠ cand: cand ← sync2 and cnt ← 0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - When sync2 = cand and cnt = DEBOUNCE_CYCLES-1: stable ← cand. The counter then saturates.
- Edge detection is evaluated only on the cycle stable is updated:
  - rise = cand & ~stable
  - fall = ~cand & stable
  - The selected set per EDGE_MODE is OR-ed into edgecapture.
- primed flag:
  - Reset to 0. Set to 1 on the first stable update after reset.
  - Edge capture is suppressed while primed = 0, so switches already set at power-up do not interrupt.
- Simultaneous events: if a clear write hits a bit on the same cycle that bit is being set, the set wins and the bit stays 1.
- irq is combinational from the edgecapture and irqmask registers. No glitch path from in_port exists.

## Timing
- Reset: all of the following are 0.
  - Outputs: readdata, out_port, irq.
  - Internal: irqmask, edgecapture, sync1/2, cand, cnt, stable, primed.
  - Reset takes effect asynchronously at any time, including mid-debounce. The count restarts from 0 afterwards.
- Read latency is 1 cycle. readdata is updated every clk from the address mux, whether or not chipselect is asserted.
- Write effect is visible in the register on the cycle after the write edge. out_port and irq update with that same edge.
- Input latency, for in_port changing before edge k and held stable:
  - sync2 is new after edge k+2.
  - cand is new after edge k+3, with cnt = 0.
  - stable and edgecapture update at edge k+3+DEBOUNCE_CYCLES.
  - irq rises in that same cycle if the bit is masked in.
- Bounce: any change of sync2 before acceptance restarts cnt at 0. A pulse shorter than DEBOUNCE_CYCLES+1 cycles at sync2 is never accepted.
- Multi-bit changes: if bits change on different cycles, the last change restarts the window. All pending bits are accepted together.

## Test plan
- Reset and priming (WIDTH=18, DEBOUNCE_CYCLES=4, EDGE_MODE=2):
  - in_port = 0x2A5A5 held through reset, then reset released.
  - Address 0 reads 0x2A5A5 starting 8 cycles after release.
  - edgecapture reads 0 and irq stays 0.
- Rising edge and interrupt:
  - irqmask = 0x00001, then in_port bit0 toggled 0→1.
  - stable bit0 = 1 at edge k+7. edgecapture = 0x00001 and irq = 1 in the same cycle.
  - Writing 0x00001 to address 2 clears edgecapture and drops irq the next cycle.
- Bounce rejection:
  - bit3 toggled with pulses of 1, 2 and 3 cycles at sync2.
  - stable, edgecapture and irq are unchanged.
  - A 5-cycle hold is accepted.
- EDGE_MODE=0 (rising only): bit5 toggled 0→1→0 gives edgecapture = 0x00020 only after the rise; the fall adds nothing.
- Clear/set collision:
  - Write 0x00004 to address 2 on the exact edge where bit2 is being captured.
  - edgecapture bit2 = 1 afterwards.
- out_port and readback:
  - Write 0x3FFFF then 0x12345 to address 0.
  - out_port follows one cycle after each write. Address 3 reads 0x12345.
  - A write with chipselect=0 is ignored.

Source files
------------

// File: rtl/pio_in_debounce_irq_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
interface pio_in_debounce_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_in_debounce_irq.sv
// Switch/button PIO: 2-flop sync, shared-counter debounce, sticky edge capture
// with masked level interrupt, plus an output latch with readback.
module pio_in_debounce_irq #(
    parameter int unsigned WIDTH           = 18,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_MODE       = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_in_debounce_irq_if.slave bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic                 irq
);
    localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             primed_q, primed_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ec_q, ec_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             wr;
    logic             accept;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edges;
    logic             unused_wdata;

    assign unused_wdata = ^bus.writedata;

    always_comb begin
        wr     = bus.chipselect & ~bus.write_n;
        wdata  = bus.writedata[WIDTH-1:0];
        accept = (sync2_q == cand_q) && (cnt_q == CNT_MAX);

        if (EDGE_MODE == 0)      edges = cand_q & ~stable_q;
        else if (EDGE_MODE == 1) edges = ~cand_q & stable_q;
        else                     edges = cand_q ^ stable_q;

        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        stable_d = accept ? cand_q : stable_q;
        primed_d = primed_q | accept;

        // clear is applied before set so a same-cycle capture wins
        ec_d = ec_q;
        if (wr && bus.address == 2'd2) ec_d = ec_d & ~wdata;
        if (accept && primed_q)        ec_d = ec_d | edges;

        mask_d = (wr && bus.address == 2'd1) ? wdata : mask_q;
        out_d  = (wr && bus.address == 2'd0) ? wdata : out_q;

        rdata_d = '0;
        case (bus.address)
            2'd0:    rdata_d[WIDTH-1:0] = stable_q;
            2'd1:    rdata_d[WIDTH-1:0] = mask_q;
            2'd2:    rdata_d[WIDTH-1:0] = ec_q;
            default: rdata_d[WIDTH-1:0] = out_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            primed_q <= 1'b0;
            mask_q   <= '0;
            ec_q     <= '0;
            out_q    <= '0;
            rdata_q  <= '0;
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            primed_q <= primed_d;
            mask_q   <= mask_d;
            ec_q     <= ec_d;
            out_q    <= out_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign out_port     = out_q;
    assign irq          = |(ec_q & mask_q);
endmodule
